// File: rtl/rv32i_pkg.sv
// Shared RV32I cache definitions: line geometry macros, cache operation codes
// and the tag/index/word key used by the instruction ROM cache.
`ifndef CACHE_WORD_ADR_SIZE
`define CACHE_WORD_ADR_SIZE 2
`endif
`ifndef CACHE_LENGTH
`define CACHE_LENGTH 16
`endif

package rv32i;

    typedef enum logic [1:0] {
        CACHE_NONE   = 2'd0,
        CACHE_LOOKUP = 2'd1,
        CACHE_STORE  = 2'd2,
        CACHE_INVAL  = 2'd3
    } cache_op_e;

    localparam int CACHE_WORD_W   = `CACHE_WORD_ADR_SIZE;
    localparam int CACHE_OFFSET_W = `CACHE_WORD_ADR_SIZE + 2;
    localparam int CACHE_INDEX_W  = $clog2(`CACHE_LENGTH);
    localparam int CACHE_TAG_W    = 32 - CACHE_INDEX_W - CACHE_OFFSET_W;

    typedef struct packed {
        logic [CACHE_TAG_W-1:0]   tag;
        logic [CACHE_INDEX_W-1:0] index;
        logic [CACHE_WORD_W-1:0]  word_addr;
    } rv32i_rom_cache_key_s;

    // The key is simply the byte address with the two byte-select bits dropped.
    function automatic rv32i_rom_cache_key_s rom_cache_key(input logic [31:0] addr);
        logic [29:0] key_bits;
        key_bits = 30'(addr >> 2);
        return key_bits;
    endfunction

endpackage

// File: rtl/rom_cache_refill_if.sv
// Backing-memory word read port used by the ROM cache refill engine.
interface rom_cache_refill_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/rom_cache_refill.sv
// Instruction ROM cache line refill: fetches a whole line word by word from
// backing memory, then presents it to the cache for a single-cycle store.
module rom_cache_refill
    import rv32i::*;
#(
    parameter int WORDS  = 2**`CACHE_WORD_ADR_SIZE,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_valid,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic                 abort,
    output logic                 busy,
    output logic                 refill_done,
    rom_cache_refill_if.master   mem,
    output cache_op_e            cache_op,
    output rv32i_rom_cache_key_s cache_key,
    output logic [31:0]          cache_wdata [WORDS]
);

    localparam int CNT_W = `CACHE_WORD_ADR_SIZE;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STORE} state_e;

    state_e               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [ADDR_W-1:0]    base_reg;
    logic                 mem_req_reg;
    logic [ADDR_W-1:0]    mem_addr_reg;
    logic                 busy_reg;
    logic                 done_reg;
    cache_op_e            op_reg;
    rv32i_rom_cache_key_s key_reg;
    logic [31:0]          buf_reg [WORDS];

    logic [ADDR_W-1:0]    line_base;
    logic [CNT_W-1:0]     cnt_inc;

    assign line_base = miss_addr & ~ADDR_W'((1 << CACHE_OFFSET_W) - 1);
    assign cnt_inc   = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            base_reg     <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            op_reg       <= CACHE_NONE;
            key_reg      <= '0;
            for (int i = 0; i < WORDS; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            op_reg   <= CACHE_NONE;
            case (state_reg)
                IDLE: begin
                    if (miss_valid && !abort) begin
                        state_reg    <= FETCH;
                        cnt_reg      <= '0;
                        base_reg     <= line_base;
                        key_reg      <= rom_cache_key(32'(miss_addr));
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= line_base;
                        busy_reg     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        if (abort) begin
                            state_reg   <= IDLE;
                            cnt_reg     <= '0;
                            mem_req_reg <= 1'b0;
                            busy_reg    <= 1'b0;
                        end else begin
                            buf_reg[cnt_reg] <= mem.mem_rdata;
                            if (cnt_reg == LAST_WORD) begin
                                // Store outputs are registered here so they line up with STORE.
                                state_reg   <= STORE;
                                cnt_reg     <= '0;
                                mem_req_reg <= 1'b0;
                                done_reg    <= 1'b1;
                                op_reg      <= CACHE_STORE;
                            end else begin
                                cnt_reg      <= cnt_inc;
                                mem_addr_reg <= base_reg | ADDR_W'({cnt_inc, 2'b00});
                            end
                        end
                    end else if (abort) begin
                        // A read already issued must still complete before going idle.
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem.mem_ack) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= '0;
                        mem_req_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                end
                STORE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem.mem_req  = mem_req_reg;
    assign mem.mem_addr = mem_addr_reg;
    assign busy         = busy_reg;
    assign refill_done  = done_reg;
    assign cache_op     = op_reg;
    assign cache_key    = key_reg;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_wdata
            assign cache_wdata[gi] = buf_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_rom_cache_refill.sv
// Scoreboard bench for rom_cache_refill: a latency-programmable memory responder
// checks request order/stability, a monitor checks every cache store.
module tb_rom_cache_refill;
    import rv32i::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 miss_valid;
    logic [31:0]          miss_addr;
    logic                 abort;
    logic                 busy;
    logic                 refill_done;
    cache_op_e            cache_op;
    rv32i_rom_cache_key_s cache_key;
    logic [31:0]          cache_wdata [4];

    rom_cache_refill_if #(.ADDR_W(32)) mem_if ();

    rom_cache_refill #(.WORDS(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_valid  (miss_valid),
        .miss_addr   (miss_addr),
        .abort       (abort),
        .busy        (busy),
        .refill_done (refill_done),
        .mem         (mem_if),
        .cache_op    (cache_op),
        .cache_key   (cache_key),
        .cache_wdata (cache_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        int           cyc;
        logic [29:0]  key;
        logic [127:0] words;  // {w3, w2, w1, w0}
    } store_t;

    req_t   addr_q  [$];
    store_t store_q [$];
    int     lat_q   [$];

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endfunction

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_line(input int n0, input logic [31:0] base, input int lat,
                             input int store_cyc, input logic [29:0] key, input logic [127:0] words);
        req_t   r;
        store_t s;
        for (int i = 0; i < 4; i++) begin
            r.cyc  = (lat == 0) ? n0 + 1 + i : n0 + 1 + i * (lat + 1);
            r.addr = base + 32'(4 * i);
            addr_q.push_back(r);
            lat_q.push_back(lat);
        end
        if (store_cyc >= 0) begin
            s.cyc   = store_cyc;
            s.key   = key;
            s.words = words;
            store_q.push_back(s);
        end
    endtask

    // Memory responder: acks each request after its queued latency, data = ~addr.
    initial begin
        bit          pending;
        int          wcnt;
        int          lat;
        logic [31:0] paddr;
        req_t        r;
        pending = 0;
        wcnt    = 0;
        lat     = 0;
        paddr   = '0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_if.mem_ack = 1'b0;
            if (rst) begin
                pending = 0;
                lat_q.delete();
            end else if (mem_if.mem_req || pending) begin
                if (pending) begin
                    chk("req_held", 64'(mem_if.mem_req), 64'(1'b1));
                    chk("addr_held", 64'(mem_if.mem_addr), 64'(paddr));
                end else begin
                    pending = 1;
                    wcnt    = 0;
                    paddr   = mem_if.mem_addr;
                    lat     = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                    if (addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_unexpected: cyc=%0d got addr=%h expected no request", cyc, paddr);
                    end else begin
                        r = addr_q.pop_front();
                        chk("req_addr", 64'(paddr), 64'(r.addr));
                        chk("req_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end
                if (wcnt == lat) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = ~paddr;
                    pending          = 0;
                end
                wcnt++;
            end
        end
    end

    // Store monitor: every store cycle must match the oldest scoreboard entry.
    initial begin
        store_t s;
        forever begin
            @(negedge clk);
            if (!rst && (refill_done || cache_op != CACHE_NONE)) begin
                if (store_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL store_unexpected: cyc=%0d got op=%0d done=%0b expected no store",
                             cyc, cache_op, refill_done);
                end else begin
                    s = store_q.pop_front();
                    chk("store_cycle", 64'(cyc), 64'(s.cyc));
                    chk("store_done", 64'(refill_done), 64'(1'b1));
                    chk("store_op", 64'(cache_op), 64'(CACHE_STORE));
                    chk("store_key", 64'(cache_key), 64'(s.key));
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("store_w%0d", i), 64'(cache_wdata[i]), 64'(s.words[32*i +: 32]));
                    end
                    $display("txn store cyc=%0d key=%h w0=%h w3=%h", cyc, cache_key, cache_wdata[0], cache_wdata[3]);
                end
            end
        end
    end

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_done"}, 64'(refill_done), 64'(1'b0));
        chk({tag, "_req"}, 64'(mem_if.mem_req), 64'(1'b0));
        chk({tag, "_addr"}, 64'(mem_if.mem_addr), 64'(0));
        chk({tag, "_op"}, 64'(cache_op), 64'(CACHE_NONE));
        chk({tag, "_key"}, 64'(cache_key), 64'(0));
        for (int i = 0; i < 4; i++) chk({tag, "_wdata"}, 64'(cache_wdata[i]), 64'(0));
    endtask

    initial begin
        int n0;
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back acks, miss on word 2 of line 0x1230.
        n0 = cyc;
        push_line(n0, 32'h0000_1230, 0, n0 + 5, {24'h000012, 4'h3, 2'h2},
                  {32'hFFFF_EDC3, 32'hFFFF_EDC7, 32'hFFFF_EDCB, 32'hFFFF_EDCF});
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1238;
        @(negedge clk);
        miss_valid = 1'b0;
        chk("t1_busy", 64'(busy), 64'(1'b1));
        at_cyc(n0 + 5);
        chk("t1_word_addr", 64'(cache_key.word_addr), 64'(2));
        at_cyc(n0 + 8);
        chk("t1_wdata_hold", 64'(cache_wdata[2]), 64'(32'hFFFF_EDC7));
        chk("t1_idle", 64'(busy), 64'(1'b0));

        // Three wait cycles per word: store lands in cycle 17.
        n0 = cyc;
        push_line(n0, 32'h0000_2000, 3, n0 + 17, {24'h000020, 4'h0, 2'h1},
                  {32'hFFFF_DFF3, 32'hFFFF_DFF7, 32'hFFFF_DFFB, 32'hFFFF_DFFF});
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_2004;
        @(negedge clk);
        miss_valid = 1'b0;
        at_cyc(n0 + 20);

        // Abort while word 1 is outstanding: drain, no store.
        n0 = cyc;
        addr_q.push_back('{n0 + 1, 32'h0000_1230});
        addr_q.push_back('{n0 + 2, 32'h0000_1234});
        lat_q.push_back(0);
        lat_q.push_back(2);
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1238;
        @(negedge clk);
        miss_valid = 1'b0;
        at_cyc(n0 + 2);
        abort = 1'b1;
        at_cyc(n0 + 3);
        abort = 1'b0;
        chk("t3_drain_req", 64'(mem_if.mem_req), 64'(1'b1));
        chk("t3_drain_addr", 64'(mem_if.mem_addr), 64'(32'h0000_1234));
        at_cyc(n0 + 5);
        chk("t3_idle_busy", 64'(busy), 64'(1'b0));
        chk("t3_idle_req", 64'(mem_if.mem_req), 64'(1'b0));
        at_cyc(n0 + 7);

        // Abort together with the last word's ack: no store.
        n0 = cyc;
        push_line(n0, 32'h0000_1230, 0, -1, '0, '0);
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1238;
        @(negedge clk);
        miss_valid = 1'b0;
        at_cyc(n0 + 4);
        abort = 1'b1;
        at_cyc(n0 + 5);
        abort = 1'b0;
        chk("t4_busy", 64'(busy), 64'(1'b0));
        chk("t4_done", 64'(refill_done), 64'(1'b0));
        at_cyc(n0 + 7);

        // Abort during STORE (and the following IDLE) is ignored.
        n0 = cyc;
        push_line(n0, 32'h0000_1230, 0, n0 + 5, {24'h000012, 4'h3, 2'h2},
                  {32'hFFFF_EDC3, 32'hFFFF_EDC7, 32'hFFFF_EDCB, 32'hFFFF_EDCF});
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1238;
        @(negedge clk);
        miss_valid = 1'b0;
        at_cyc(n0 + 5);
        abort = 1'b1;
        at_cyc(n0 + 7);
        abort = 1'b0;
        chk("t4b_idle", 64'(busy), 64'(1'b0));

        // Reset mid-FETCH, then a normal refill.
        n0 = cyc;
        addr_q.push_back('{n0 + 1, 32'h0000_3000});
        lat_q.push_back(5);
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3000;
        @(negedge clk);
        miss_valid = 1'b0;
        at_cyc(n0 + 2);
        rst = 1'b1;
        at_cyc(n0 + 3);
        rst = 1'b0;
        chk_idle_reset("t5_rst");
        at_cyc(n0 + 4);
        n0 = cyc;
        push_line(n0, 32'h0000_4AB0, 0, n0 + 5, {24'h00004A, 4'hB, 2'h3},
                  {32'hFFFF_B543, 32'hFFFF_B547, 32'hFFFF_B54B, 32'hFFFF_B54F});
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_4ABC;
        @(negedge clk);
        miss_valid = 1'b0;
        at_cyc(n0 + 7);

        // New address while busy is ignored; requester holds miss_valid until done.
        n0 = cyc;
        push_line(n0, 32'h0000_5010, 0, n0 + 5, {24'h000050, 4'h1, 2'h0},
                  {32'hFFFF_AFE3, 32'hFFFF_AFE7, 32'hFFFF_AFEB, 32'hFFFF_AFEF});
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_5010;
        @(negedge clk);
        miss_addr  = 32'h0000_6020;
        at_cyc(n0 + 5);
        miss_valid = 1'b0;
        at_cyc(n0 + 7);
        chk("t6_no_restart", 64'(busy), 64'(1'b0));

        // miss_valid with abort in IDLE must not start a refill.
        miss_valid = 1'b1;
        abort      = 1'b1;
        miss_addr  = 32'h0000_7000;
        @(negedge clk);
        miss_valid = 1'b0;
        abort      = 1'b0;
        chk("t7_busy", 64'(busy), 64'(1'b0));
        chk("t7_req", 64'(mem_if.mem_req), 64'(1'b0));
        repeat (3) @(negedge clk);

        chk("end_store_q", 64'(store_q.size()), 64'(0));
        chk("end_addr_q", 64'(addr_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_cache_refill.md
ROM_CACHE_REFILL -- requirements
Module: rom_cache_refill

Interface
REQ-001 SHALL have parameter WORDS, default 2**`CACHE_WORD_ADR_SIZE (4), words per cache line.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 miss_valid  input  1  refill request, sampled only in IDLE.
REQ-006 miss_addr  input  ADDR_W  byte address of missed instruction fetch.
REQ-007 abort  input  1  cancel in-flight refill (pipeline redirect).
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 refill_done  output  1  one-cycle pulse coincident with the cache store.
REQ-010 mem_req  output  1  backing-memory word read request.
REQ-011 mem_addr  output  ADDR_W  word-aligned read address.
REQ-012 mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-013 mem_rdata  input  32  returned word.
REQ-014 cache_op  output  cache_op_e  CACHE_STORE during store cycle, else CACHE_NONE.
REQ-015 cache_key  output  rv32i_rom_cache_key_s  tag/index/word_addr of the latched miss.
REQ-016 cache_wdata  output  32 x WORDS (unpacked)  assembled line, element i = word i.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, STORE.
- IDLE -> FETCH when miss_valid=1 and abort=0; latch miss_addr; word counter cleared to 0.
- FETCH: mem_req=1, mem_addr = line base + 4*cnt; line base = miss_addr with low (`CACHE_WORD_ADR_SIZE+2) bits zeroed.
- FETCH, mem_ack=1: buffer[cnt] <= mem_rdata, cnt++; if cnt==WORDS-1 -> STORE.
- FETCH, abort=1, mem_ack=0 -> DRAIN; abort=1 with mem_ack=1 -> IDLE, no store.
- DRAIN: hold mem_req=1 and mem_addr unchanged until mem_ack, then IDLE; data discarded.
- STORE: one cycle, cache_op=CACHE_STORE, refill_done=1, then IDLE; abort ignored.
REQ-018 SHALL never deassert mem_req or change mem_addr while mem_ack is pending (no request withdrawal).
REQ-019 SHALL issue words strictly in order 0..WORDS-1; one outstanding read at a time.
REQ-020 Minimum latency: accept in cycle 0, mem_ack every cycle -> words in cycles 1..4, STORE in cycle 5.
REQ-021 cache_key SHALL carry the original miss word_addr so the cache forwards the requested word in the STORE cycle.
REQ-022 cache_wdata SHALL hold buffered words stably from STORE until the next accepted miss.
REQ-023 miss_valid outside IDLE SHALL be ignored; requester holds it until refill_done.
REQ-024 abort in IDLE SHALL have no effect; miss_valid and abort together in IDLE SHALL not start a refill.
REQ-025 Counter wrap: cnt width `CACHE_WORD_ADR_SIZE; SHALL not wrap before STORE.

Reset
REQ-026 rst=1 SHALL force IDLE, cnt=0, busy=0, refill_done=0, mem_req=0, mem_addr=0, cache_op=CACHE_NONE, cache_key=0, cache_wdata all 0.
REQ-027 rst mid-FETCH/DRAIN SHALL drop mem_req next cycle; backing memory is reset on the same rst.

Structure
REQ-028 cache_op_e (incl. CACHE_NONE, CACHE_STORE), rv32i_rom_cache_key_s, `CACHE_WORD_ADR_SIZE, `CACHE_LENGTH SHALL come from package rv32i; no local redefinition.
REQ-029 State enum SHALL be local to the module; no sub-module required.

Verification
REQ-030 miss_addr=0x0000_1238, mem_ack every cycle -> mem_addr 0x1230,0x1234,0x1238,0x123C in cycles 1-4; CACHE_STORE + refill_done in cycle 5; cache_key.word_addr=2.
REQ-031 mem_ack delayed 3 cycles per word -> mem_req/mem_addr stable while waiting; STORE in cycle 17; wdata matches returned words in order.
REQ-032 abort in cycle 2 with mem_ack low, ack at cycle 4 -> DRAIN holds addr 0x1234 until ack, IDLE cycle 5, no CACHE_STORE, no refill_done.
REQ-033 abort coincident with mem_ack of word 3 -> IDLE next cycle, no store; abort during STORE -> store still completes.
REQ-034 rst asserted mid-FETCH -> next cycle all outputs at reset values; new miss then completes normally.
REQ-035 miss_valid asserted with new address while busy -> ignored; key reflects first address only.
